// File: rtl/router_pkg.sv
// Router-wide types and sizing shared by the allocators and the switch path.
// VC_SIZE is the downstream buffer depth, so it is also the reset credit count.
package router_pkg;

    typedef enum logic [1:0] {
        FLIT_HEAD   = 2'd0,
        FLIT_BODY   = 2'd1,
        FLIT_TAIL   = 2'd2,
        FLIT_SINGLE = 2'd3
    } flit_type_e;

    localparam int VC_SIZE    = 4;
    localparam int NUM_OVC    = 4;
    localparam int OVC_W      = $clog2(NUM_OVC);
    localparam int CREDIT_MAX = VC_SIZE;
    localparam int CREDIT_W   = $clog2(CREDIT_MAX + 1);

    // Tail and single flits both end a packet and so release its VC.
    function automatic logic flit_ends_pkt(flit_type_e t);
        return (t == FLIT_TAIL) || (t == FLIT_SINGLE);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first requester at or after the pointer, wrapping.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller gates o_grant with its own resource check.
module rr_arbiter #(
    parameter int NUM_REQ = 8,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PTR_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic               o_grant_vld
);

    logic [PTR_W-1:0] w_idx;

    always_comb begin
        o_grant     = '0;
        o_grant_vld = 1'b0;
        w_idx       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_idx = PTR_W'((int'(i_ptr) + i) % NUM_REQ);
            if (!o_grant_vld && i_req[w_idx]) begin
                o_grant[w_idx] = 1'b1;
                o_grant_vld    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ovc_allocator.sv
// Output-VC allocator and downstream credit tracker for one router output port.
// Latency: req sampled at edge N gives a one-cycle grant pulse at edge N+1.
// Backpressure: no grant while every OVC is owned; credits are tracked, not enforced.
module ovc_allocator #(
    parameter int NUM_REQ    = 8,
    parameter int NUM_OVC    = router_pkg::NUM_OVC,
    parameter int OVC_W      = router_pkg::OVC_W,
    parameter int CREDIT_MAX = router_pkg::CREDIT_MAX,
    parameter int CREDIT_W   = router_pkg::CREDIT_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req,
    output logic [NUM_REQ-1:0]           grant,
    output logic [OVC_W-1:0]             grant_ovc,
    input  logic                         send_valid,
    input  logic [OVC_W-1:0]             send_ovc,
    input  logic                         send_tail,
    input  logic                         credit_valid,
    input  logic [OVC_W-1:0]             credit_ovc,
    output logic [NUM_OVC-1:0]           ovc_busy,
    output logic [NUM_OVC*CREDIT_W-1:0]  ovc_credit,
    output logic                         credit_err
);

    localparam int                PTR_W = $clog2(NUM_REQ);
    localparam logic [CREDIT_W-1:0] C_MAX = CREDIT_W'(CREDIT_MAX);

    logic [NUM_REQ-1:0]  r_grant;
    logic [OVC_W-1:0]    r_grant_ovc;
    logic [NUM_OVC-1:0]  r_busy;
    logic [PTR_W-1:0]    r_ptr;
    logic                r_err;
    logic [CREDIT_W-1:0] r_credit [NUM_OVC];

    logic [NUM_REQ-1:0]  w_eligible;
    logic [NUM_REQ-1:0]  w_arb_grant;
    logic                w_arb_vld;
    logic                w_free_any;
    logic [OVC_W-1:0]    w_free_idx;
    logic                w_alloc;
    logic [PTR_W-1:0]    w_win_idx;
    logic [PTR_W-1:0]    w_ptr_nxt;
    logic [NUM_OVC-1:0]  w_alloc_mask;
    logic [NUM_OVC-1:0]  w_rel;
    logic [NUM_OVC-1:0]  w_dec;
    logic [NUM_OVC-1:0]  w_inc;
    logic [CREDIT_W-1:0] w_credit_nxt [NUM_OVC];
    logic                w_err_nxt;

    // The requester still seeing its grant is masked so a lingering req is not re-granted.
    assign w_eligible = req & ~r_grant;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_arb (
        .i_req       (w_eligible),
        .i_ptr       (r_ptr),
        .o_grant     (w_arb_grant),
        .o_grant_vld (w_arb_vld)
    );

    always_comb begin
        w_free_any = 1'b0;
        w_free_idx = '0;
        for (int k = NUM_OVC - 1; k >= 0; k--) begin
            if (!r_busy[k]) begin
                w_free_any = 1'b1;
                w_free_idx = OVC_W'(k);
            end
        end
    end

    always_comb begin
        w_win_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_arb_grant[i]) w_win_idx = PTR_W'(i);
        end
    end

    assign w_alloc   = w_arb_vld && w_free_any;
    assign w_ptr_nxt = (w_win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : w_win_idx + 1'b1;

    always_comb begin
        w_alloc_mask = '0;
        w_rel        = '0;
        w_dec        = '0;
        w_inc        = '0;
        for (int k = 0; k < NUM_OVC; k++) begin
            w_alloc_mask[k] = w_alloc && (w_free_idx == OVC_W'(k));
            w_rel[k]        = send_valid && send_tail && (send_ovc == OVC_W'(k));
            w_dec[k]        = send_valid && (send_ovc == OVC_W'(k));
            w_inc[k]        = credit_valid && (credit_ovc == OVC_W'(k));
        end
    end

    // Underflow and overflow saturate and raise the sticky error.
    always_comb begin
        w_err_nxt = r_err;
        if (send_valid && !r_busy[send_ovc]) w_err_nxt = 1'b1;
        for (int k = 0; k < NUM_OVC; k++) begin
            w_credit_nxt[k] = r_credit[k];
            if (w_dec[k] && !w_inc[k]) begin
                if (r_credit[k] == '0) w_err_nxt = 1'b1;
                else                   w_credit_nxt[k] = r_credit[k] - 1'b1;
            end else if (w_inc[k] && !w_dec[k]) begin
                if (r_credit[k] == C_MAX) w_err_nxt = 1'b1;
                else                      w_credit_nxt[k] = r_credit[k] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant     <= '0;
            r_grant_ovc <= '0;
            r_busy      <= '0;
            r_ptr       <= '0;
            r_err       <= 1'b0;
            for (int k = 0; k < NUM_OVC; k++) r_credit[k] <= C_MAX;
        end else begin
            r_busy   <= (r_busy & ~w_rel) | w_alloc_mask;
            r_credit <= w_credit_nxt;
            r_err    <= w_err_nxt;
            if (w_alloc) begin
                r_grant     <= w_arb_grant;
                r_grant_ovc <= w_free_idx;
                r_ptr       <= w_ptr_nxt;
            end else begin
                r_grant     <= '0;
            end
        end
    end

    assign grant      = r_grant;
    assign grant_ovc  = r_grant_ovc;
    assign ovc_busy   = r_busy;
    assign credit_err = r_err;

    for (genvar k = 0; k < NUM_OVC; k++) begin : g_credit_out
        assign ovc_credit[k*CREDIT_W +: CREDIT_W] = r_credit[k];
    end

endmodule

// File: tb/tb_ovc_allocator.sv
// Directed table-driven bench for ovc_allocator plus a few hand-written sequences.
// Inputs change on the falling edge; outputs are checked 1 time unit after the rising edge.
module tb_ovc_allocator;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  req;
    logic [7:0]  grant;
    logic [1:0]  grant_ovc;
    logic        send_valid;
    logic [1:0]  send_ovc;
    logic        send_tail;
    logic        credit_valid;
    logic [1:0]  credit_ovc;
    logic [3:0]  ovc_busy;
    logic [11:0] ovc_credit;
    logic        credit_err;

    int n_tests = 0;
    int n_fail  = 0;

    ovc_allocator dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .grant        (grant),
        .grant_ovc    (grant_ovc),
        .send_valid   (send_valid),
        .send_ovc     (send_ovc),
        .send_tail    (send_tail),
        .credit_valid (credit_valid),
        .credit_ovc   (credit_ovc),
        .ovc_busy     (ovc_busy),
        .ovc_credit   (ovc_credit),
        .credit_err   (credit_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [7:0]  req;
        logic        sv;
        logic [1:0]  so;
        logic        st;
        logic        cv;
        logic [1:0]  co;
        logic [7:0]  e_grant;
        logic [1:0]  e_govc;
        logic [3:0]  e_busy;
        logic [11:0] e_cr;
        logic        e_err;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [11:0] cr(int c3, int c2, int c1, int c0);
        return {3'(c3), 3'(c2), 3'(c1), 3'(c0)};
    endfunction

    function automatic vec_t mk(logic r, logic [7:0] rq, logic sv, logic [1:0] so, logic st,
                                logic cv, logic [1:0] co, logic [7:0] eg, logic [1:0] eo,
                                logic [3:0] eb, logic [11:0] ec, logic ee);
        vec_t v;
        v.rst = r; v.req = rq; v.sv = sv; v.so = so; v.st = st; v.cv = cv; v.co = co;
        v.e_grant = eg; v.e_govc = eo; v.e_busy = eb; v.e_cr = ec; v.e_err = ee;
        return v;
    endfunction

    task automatic check(string nm, int row, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (step %0d): got 'h%0h, expected 'h%0h", nm, row, act, exp);
        end
    endtask

    task automatic cyc(logic r, logic [7:0] rq, logic sv, logic [1:0] so, logic st,
                       logic cv, logic [1:0] co);
        @(negedge clk);
        rst = r; req = rq; send_valid = sv; send_ovc = so; send_tail = st;
        credit_valid = cv; credit_ovc = co;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; req = '0; send_valid = 1'b0; send_ovc = '0; send_tail = 1'b0;
        credit_valid = 1'b0; credit_ovc = '0;

        //          rst req    sv so st cv co  grant  govc busy     credits        err
        vecs.push_back(mk(1, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0, 4'b0000, cr(4,4,4,4), 0));
        // Two requesters held: 0 then 2, OVCs 0 then 1.
        vecs.push_back(mk(0, 8'h05, 0, 0, 0, 0, 0, 8'h01, 0, 4'b0001, cr(4,4,4,4), 0));
        vecs.push_back(mk(0, 8'h05, 0, 0, 0, 0, 0, 8'h04, 1, 4'b0011, cr(4,4,4,4), 0));
        vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0, 4'b0011, cr(4,4,4,4), 0));
        // Pointer at 3: req[1] wins after wrap, then req[3].
        vecs.push_back(mk(0, 8'h02, 0, 0, 0, 0, 0, 8'h02, 2, 4'b0111, cr(4,4,4,4), 0));
        vecs.push_back(mk(0, 8'h08, 0, 0, 0, 0, 0, 8'h08, 3, 4'b1111, cr(4,4,4,4), 0));
        // All OVCs busy: req[5] waits; release of OVC 2 is not bypassed.
        vecs.push_back(mk(0, 8'h20, 0, 0, 0, 0, 0, 8'h00, 0, 4'b1111, cr(4,4,4,4), 0));
        vecs.push_back(mk(0, 8'h20, 1, 2, 1, 0, 0, 8'h00, 0, 4'b1011, cr(4,3,4,4), 0));
        vecs.push_back(mk(0, 8'h20, 0, 0, 0, 0, 0, 8'h20, 2, 4'b1111, cr(4,3,4,4), 0));
        // Simultaneous send and credit on OVC 1.
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(0, 8'h00, 1, 1, 0, 1, 1, 8'h00, 0, 4'b1111, cr(4,3,4,4), 0));
        // Exhaust OVC 0, then underflow.
        vecs.push_back(mk(0, 8'h00, 1, 0, 0, 0, 0, 8'h00, 0, 4'b1111, cr(4,3,4,3), 0));
        vecs.push_back(mk(0, 8'h00, 1, 0, 0, 0, 0, 8'h00, 0, 4'b1111, cr(4,3,4,2), 0));
        vecs.push_back(mk(0, 8'h00, 1, 0, 0, 0, 0, 8'h00, 0, 4'b1111, cr(4,3,4,1), 0));
        vecs.push_back(mk(0, 8'h00, 1, 0, 0, 0, 0, 8'h00, 0, 4'b1111, cr(4,3,4,0), 0));
        vecs.push_back(mk(0, 8'h00, 1, 0, 0, 0, 0, 8'h00, 0, 4'b1111, cr(4,3,4,0), 1));
        vecs.push_back(mk(0, 8'h00, 0, 0, 0, 1, 2, 8'h00, 0, 4'b1111, cr(4,4,4,0), 1));
        vecs.push_back(mk(0, 8'h00, 0, 0, 0, 1, 0, 8'h00, 0, 4'b1111, cr(4,4,4,1), 1));
        // Reset with activity on every input.
        vecs.push_back(mk(1, 8'hFF, 1, 0, 1, 1, 3, 8'h00, 0, 4'b0000, cr(4,4,4,4), 0));
        // Credit overflow on OVC 3.
        vecs.push_back(mk(0, 8'h00, 0, 0, 0, 1, 3, 8'h00, 0, 4'b0000, cr(4,4,4,4), 1));
        vecs.push_back(mk(1, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0, 4'b0000, cr(4,4,4,4), 0));
        // Send on an unowned OVC: error, but credit still consumed.
        vecs.push_back(mk(0, 8'h00, 1, 1, 0, 0, 0, 8'h00, 0, 4'b0000, cr(4,4,3,4), 1));
        vecs.push_back(mk(1, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0, 4'b0000, cr(4,4,4,4), 0));
        // Drain OVC 0, then send+credit at zero is neutral and error-free.
        vecs.push_back(mk(0, 8'h01, 0, 0, 0, 0, 0, 8'h01, 0, 4'b0001, cr(4,4,4,4), 0));
        vecs.push_back(mk(0, 8'h00, 1, 0, 0, 0, 0, 8'h00, 0, 4'b0001, cr(4,4,4,3), 0));
        vecs.push_back(mk(0, 8'h00, 1, 0, 0, 0, 0, 8'h00, 0, 4'b0001, cr(4,4,4,2), 0));
        vecs.push_back(mk(0, 8'h00, 1, 0, 0, 0, 0, 8'h00, 0, 4'b0001, cr(4,4,4,1), 0));
        vecs.push_back(mk(0, 8'h00, 1, 0, 0, 0, 0, 8'h00, 0, 4'b0001, cr(4,4,4,0), 0));
        vecs.push_back(mk(0, 8'h00, 1, 0, 0, 1, 0, 8'h00, 0, 4'b0001, cr(4,4,4,0), 0));
        vecs.push_back(mk(1, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0, 4'b0000, cr(4,4,4,4), 0));
        // Fairness: all request, previous grant's OVC released each cycle.
        vecs.push_back(mk(0, 8'hFF, 0, 0, 0, 0, 0, 8'h01, 0, 4'b0001, cr(4,4,4,4), 0));
        vecs.push_back(mk(0, 8'hFF, 1, 0, 1, 0, 0, 8'h02, 1, 4'b0010, cr(4,4,4,3), 0));
        vecs.push_back(mk(0, 8'hFF, 1, 1, 1, 0, 0, 8'h04, 0, 4'b0001, cr(4,4,3,3), 0));
        vecs.push_back(mk(0, 8'hFF, 1, 0, 1, 0, 0, 8'h08, 1, 4'b0010, cr(4,4,3,2), 0));
        vecs.push_back(mk(0, 8'hFF, 1, 1, 1, 0, 0, 8'h10, 0, 4'b0001, cr(4,4,2,2), 0));
        vecs.push_back(mk(0, 8'hFF, 1, 0, 1, 0, 0, 8'h20, 1, 4'b0010, cr(4,4,2,1), 0));
        vecs.push_back(mk(0, 8'hFF, 1, 1, 1, 0, 0, 8'h40, 0, 4'b0001, cr(4,4,1,1), 0));
        vecs.push_back(mk(0, 8'hFF, 1, 0, 1, 0, 0, 8'h80, 1, 4'b0010, cr(4,4,1,0), 0));
        vecs.push_back(mk(0, 8'hFF, 1, 1, 1, 0, 0, 8'h01, 0, 4'b0001, cr(4,4,0,0), 0));
        // Reset mid-sequence, then the pointer restarts at 0.
        vecs.push_back(mk(1, 8'hFF, 1, 0, 1, 0, 0, 8'h00, 0, 4'b0000, cr(4,4,4,4), 0));
        vecs.push_back(mk(0, 8'hFF, 0, 0, 0, 0, 0, 8'h01, 0, 4'b0001, cr(4,4,4,4), 0));

        foreach (vecs[i]) begin
            cyc(vecs[i].rst, vecs[i].req, vecs[i].sv, vecs[i].so, vecs[i].st,
                vecs[i].cv, vecs[i].co);
            check("grant",      i, 32'(grant),      32'(vecs[i].e_grant));
            if (vecs[i].e_grant != 8'h00)
                check("grant_ovc", i, 32'(grant_ovc), 32'(vecs[i].e_govc));
            check("ovc_busy",   i, 32'(ovc_busy),   32'(vecs[i].e_busy));
            check("ovc_credit", i, 32'(ovc_credit), 32'(vecs[i].e_cr));
            check("credit_err", i, 32'(credit_err), 32'(vecs[i].e_err));
        end

        // A single req held for two cycles is granted once only.
        cyc(1, 8'h00, 0, 0, 0, 0, 0);
        cyc(0, 8'h01, 0, 0, 0, 0, 0);
        check("hold_grant1", 100, 32'(grant), 32'h01);
        cyc(0, 8'h01, 0, 0, 0, 0, 0);
        check("hold_grant2", 101, 32'(grant), 32'h00);
        check("hold_busy",   101, 32'(ovc_busy), 32'b0001);

        // Sticky error survives idle cycles and clears only on reset.
        cyc(0, 8'h00, 0, 0, 0, 1, 2);
        check("sticky_set", 102, 32'(credit_err), 32'd1);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 8'h00, 0, 0, 0, 0, 0);
            check("sticky_hold", 103 + i, 32'(credit_err), 32'd1);
        end
        cyc(1, 8'h00, 0, 0, 0, 0, 0);
        check("sticky_clr", 108, 32'(credit_err), 32'd0);
        cyc(0, 8'h00, 0, 0, 0, 0, 0);
        check("idle_grant", 109, 32'(grant), 32'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
